// File: rtl/time_entry_ctrl.sv
// Keypad time-setting controller: BCD edit buffer with a digit cursor, per-digit
// range checks, backspace/commit/cancel, and the cursor blink for the display.
module time_entry_ctrl #(
  parameter int NUM_FIELDS = 2,
  parameter int HOUR_MAX   = 23,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [2:0] cursor,
  output logic       blink,
  output logic       editing,
  output logic       set_pulse,
  output logic       err_pulse
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [2:0] LAST_CURSOR = 3'(2 * NUM_FIELDS - 1);
  localparam logic [3:0] HOUR_TENS   = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HOUR_UNITS  = 4'(HOUR_MAX % 10);

  typedef enum logic {S_IDLE, S_EDIT} state_t;

  state_t        state;
  logic [3:0]    com_d  [6];
  logic [3:0]    edit_d [6];
  logic [CW-1:0] blink_cnt;
  logic          digit_ok;
  logic          is_tens;
  logic          is_hour;
  logic [3:0]    cur_tens;

  assign editing = (state == S_EDIT);

  function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] units);
    logic [7:0] v;
    v = {4'b0, tens} * 8'd10 + {4'b0, units};
    return v[5:0];
  endfunction

  // Outputs follow the edit buffer while editing, the committed time otherwise.
  assign hour   = editing ? to_bin(edit_d[0], edit_d[1]) : to_bin(com_d[0], com_d[1]);
  assign minute = editing ? to_bin(edit_d[2], edit_d[3]) : to_bin(com_d[2], com_d[3]);
  assign second = (NUM_FIELDS != 3) ? 6'd0 :
                  (editing ? to_bin(edit_d[4], edit_d[5]) : to_bin(com_d[4], com_d[5]));

  always_comb begin
    is_tens  = ~cursor[0];
    is_hour  = (cursor[2:1] == 2'd0);
    cur_tens = edit_d[{cursor[2:1], 1'b0}];
    digit_ok = 1'b0;
    if (is_tens)
      digit_ok = is_hour ? (key_val <= HOUR_TENS) : (key_val <= 4'd5);
    else
      digit_ok = !(is_hour && (cur_tens == HOUR_TENS) && (key_val > HOUR_UNITS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cursor    <= 3'd0;
      blink     <= 1'b0;
      blink_cnt <= '0;
      set_pulse <= 1'b0;
      err_pulse <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        com_d[i]  <= 4'd0;
        edit_d[i] <= 4'd0;
      end
    end else begin
      set_pulse <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          blink_cnt <= '0;
          blink     <= 1'b0;
          if (start) begin
            state     <= S_EDIT;
            edit_d    <= com_d;
            cursor    <= 3'd0;
            blink     <= 1'b1;
          end
        end
        S_EDIT: begin
          if (start) begin
            // Cancel: the committed time is untouched, the buffer reloads on next entry.
            state     <= S_IDLE;
            cursor    <= 3'd0;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink     <= ~blink;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            if (key_valid) begin
              if (key_val <= 4'd9) begin
                if (digit_ok) begin
                  edit_d[cursor] <= key_val;
                  if (is_tens)
                    edit_d[{cursor[2:1], 1'b1}] <= 4'd0;
                  cursor    <= (cursor == LAST_CURSOR) ? cursor : cursor + 3'd1;
                  blink     <= 1'b1;
                  blink_cnt <= '0;
                end else begin
                  err_pulse <= 1'b1;
                end
              end else if (key_val == 4'hE) begin
                if (cursor != 3'd0)
                  cursor <= cursor - 3'd1;
                blink     <= 1'b1;
                blink_cnt <= '0;
              end else if (key_val == 4'hF) begin
                com_d     <= edit_d;
                set_pulse <= 1'b1;
                state     <= S_IDLE;
                cursor    <= 3'd0;
                blink     <= 1'b0;
                blink_cnt <= '0;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: two instances (hh:mm/23h/blink 4 and hh:mm:ss/12h/blink 3)
// share one stimulus stream and are each tracked by a value-level reference model.
module tb_time_entry_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_val = 4'd0;

  always #5 clk = ~clk;

  logic [5:0] hour2, minute2, second2, hour3, minute3, second3;
  logic [2:0] cursor2, cursor3;
  logic       blink2, editing2, set2, err2;
  logic       blink3, editing3, set3, err3;

  time_entry_ctrl #(.NUM_FIELDS(2), .HOUR_MAX(23), .BLINK_DIV(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_val(key_val),
    .hour(hour2), .minute(minute2), .second(second2), .cursor(cursor2),
    .blink(blink2), .editing(editing2), .set_pulse(set2), .err_pulse(err2)
  );

  time_entry_ctrl #(.NUM_FIELDS(3), .HOUR_MAX(12), .BLINK_DIV(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_val(key_val),
    .hour(hour3), .minute(minute3), .second(second3), .cursor(cursor3),
    .blink(blink3), .editing(editing3), .set_pulse(set3), .err_pulse(err3)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (values, not digits) ----------------
  int m_nf [2] = '{2, 3};
  int m_hm [2] = '{23, 12};
  int m_bd [2] = '{4, 3};
  bit m_edit [2];
  int m_com [2][3];
  int m_buf [2][3];
  int m_cur [2];
  int m_since [2];
  bit m_set [2];
  bit m_err [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_edit[i] = 0; m_cur[i] = 0; m_since[i] = 0; m_set[i] = 0; m_err[i] = 0;
      for (int f = 0; f < 3; f++) begin
        m_com[i][f] = 0;
        m_buf[i][f] = 0;
      end
    end
  endfunction

  // A digit is accepted iff the field value it produces stays within the field's range.
  function automatic void model_step(input int i, input bit s, input bit kv, input int k);
    int f, nv, maxv;
    m_set[i] = 0;
    m_err[i] = 0;
    if (!m_edit[i]) begin
      if (s) begin
        m_edit[i] = 1; m_cur[i] = 0; m_since[i] = 0;
        for (int j = 0; j < 3; j++) m_buf[i][j] = m_com[i][j];
      end
    end else if (s) begin
      m_edit[i] = 0; m_cur[i] = 0;
    end else begin
      m_since[i]++;
      if (kv) begin
        if (k <= 9) begin
          f    = m_cur[i] / 2;
          maxv = (f == 0) ? m_hm[i] : 59;
          nv   = (m_cur[i] % 2 == 0) ? k * 10 : (m_buf[i][f] / 10) * 10 + k;
          if (nv <= maxv) begin
            m_buf[i][f] = nv;
            if (m_cur[i] < 2 * m_nf[i] - 1) m_cur[i]++;
            m_since[i] = 0;
          end else begin
            m_err[i] = 1;
          end
        end else if (k == 14) begin
          if (m_cur[i] > 0) m_cur[i]--;
          m_since[i] = 0;
        end else if (k == 15) begin
          for (int j = 0; j < 3; j++) m_com[i][j] = m_buf[i][j];
          m_set[i] = 1; m_edit[i] = 0; m_cur[i] = 0;
        end
      end
    end
  endfunction

  function automatic int m_val(input int i, input int f);
    if (f >= m_nf[i]) return 0;
    return m_edit[i] ? m_buf[i][f] : m_com[i][f];
  endfunction

  function automatic int m_blink(input int i);
    return (m_edit[i] && ((m_since[i] / m_bd[i]) % 2 == 0)) ? 1 : 0;
  endfunction

  task automatic check_model();
    check("u2.hour",    int'(hour2),    m_val(0, 0));
    check("u2.minute",  int'(minute2),  m_val(0, 1));
    check("u2.second",  int'(second2),  m_val(0, 2));
    check("u2.cursor",  int'(cursor2),  m_cur[0]);
    check("u2.blink",   int'(blink2),   m_blink(0));
    check("u2.editing", int'(editing2), int'(m_edit[0]));
    check("u2.set",     int'(set2),     int'(m_set[0]));
    check("u2.err",     int'(err2),     int'(m_err[0]));
    check("u3.hour",    int'(hour3),    m_val(1, 0));
    check("u3.minute",  int'(minute3),  m_val(1, 1));
    check("u3.second",  int'(second3),  m_val(1, 2));
    check("u3.cursor",  int'(cursor3),  m_cur[1]);
    check("u3.blink",   int'(blink3),   m_blink(1));
    check("u3.editing", int'(editing3), int'(m_edit[1]));
    check("u3.set",     int'(set3),     int'(m_set[1]));
    check("u3.err",     int'(err3),     int'(m_err[1]));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit s, input bit kv, input logic [3:0] k);
    start = s; key_valid = kv; key_val = k;
    @(posedge clk);
    model_step(0, s, kv, int'(k));
    model_step(1, s, kv, int'(k));
    #1;
    check_model();
    start = 1'b0; key_valid = 1'b0; key_val = 4'd0;
  endtask

  // ---------------- directed vectors for u2 (hh:mm, HOUR_MAX 23) ----------------
  typedef struct {
    bit         s;
    bit         kv;
    logic [3:0] k;
    int         hour;
    int         minute;
    int         cur;
    bit         edit;
    bit         set;
    bit         err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit s, input bit kv, input int k, input int h, input int m,
                              input int c, input bit e, input bit st, input bit er);
    vec_t v;
    v.s = s; v.kv = kv; v.k = 4'(k); v.hour = h; v.minute = m;
    v.cur = c; v.edit = e; v.set = st; v.err = er;
    vecs.push_back(v);
  endfunction

  initial begin
    bit exp_blink [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

    model_reset();
    #2 rst = 1'b0;
    #2;
    check("reset.hour",    int'(hour2),    0);
    check("reset.minute",  int'(minute2),  0);
    check("reset.cursor",  int'(cursor2),  0);
    check("reset.blink",   int'(blink2),   0);
    check("reset.editing", int'(editing2), 0);
    check("reset.set",     int'(set2),     0);
    check("reset.err",     int'(err2),     0);
    check("reset.second3", int'(second3),  0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    //   s  kv  key    hour min cur ed set err
    add(1, 0, 0,      0,   0,  0,  1, 0, 0);
    add(0, 1, 1,      10,  0,  1,  1, 0, 0);
    add(0, 1, 2,      12,  0,  2,  1, 0, 0);
    add(0, 1, 3,      12,  30, 3,  1, 0, 0);
    add(0, 1, 4,      12,  34, 3,  1, 0, 0);
    add(0, 1, 15,     12,  34, 0,  0, 1, 0);
    add(0, 1, 5,      12,  34, 0,  0, 0, 0);
    add(1, 0, 0,      12,  34, 0,  1, 0, 0);
    add(0, 1, 3,      12,  34, 0,  1, 0, 1);
    add(0, 1, 2,      20,  34, 1,  1, 0, 0);
    add(0, 1, 4,      20,  34, 1,  1, 0, 1);
    add(0, 1, 3,      23,  34, 2,  1, 0, 0);
    add(0, 1, 4'hA,   23,  34, 2,  1, 0, 0);
    add(0, 1, 14,     23,  34, 1,  1, 0, 0);
    add(0, 1, 14,     23,  34, 0,  1, 0, 0);
    add(0, 1, 14,     23,  34, 0,  1, 0, 0);
    add(1, 0, 0,      12,  34, 0,  0, 0, 0);
    add(1, 1, 9,      12,  34, 0,  1, 0, 0);
    add(0, 1, 0,      0,   34, 1,  1, 0, 0);
    add(0, 1, 14,     0,   34, 0,  1, 0, 0);
    add(1, 0, 0,      12,  34, 0,  0, 0, 0);
    add(1, 0, 0,      12,  34, 0,  1, 0, 0);
    add(0, 1, 1,      10,  34, 1,  1, 0, 0);
    add(0, 1, 9,      19,  34, 2,  1, 0, 0);
    add(0, 1, 6,      19,  34, 2,  1, 0, 1);
    add(0, 1, 5,      19,  50, 3,  1, 0, 0);
    add(0, 1, 15,     19,  50, 0,  0, 1, 0);
    add(0, 0, 0,      19,  50, 0,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].s, vecs[i].kv, vecs[i].k);
      check($sformatf("vec%0d.hour", i),    int'(hour2),    vecs[i].hour);
      check($sformatf("vec%0d.minute", i),  int'(minute2),  vecs[i].minute);
      check($sformatf("vec%0d.cursor", i),  int'(cursor2),  vecs[i].cur);
      check($sformatf("vec%0d.editing", i), int'(editing2), int'(vecs[i].edit));
      check($sformatf("vec%0d.set", i),     int'(set2),     int'(vecs[i].set));
      check($sformatf("vec%0d.err", i),     int'(err2),     int'(vecs[i].err));
    end

    // hh:mm:ss on u3: minute tens 6 rejected, cursor saturates on the last digit.
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 9);  check("ss.hour09", int'(hour3), 9);
    cycle(0, 1, 6);  check("ss.err_min_tens", int'(err3), 1);
                     check("ss.cur_hold", int'(cursor3), 2);
    cycle(0, 1, 5);
    cycle(0, 1, 9);
    cycle(0, 1, 5);  check("ss.cur5", int'(cursor3), 5);
    cycle(0, 1, 9);  check("ss.sat_cur", int'(cursor3), 5);
                     check("ss.sec59", int'(second3), 59);
    cycle(0, 1, 8);  check("ss.sec58", int'(second3), 58);
                     check("ss.cur5b", int'(cursor3), 5);
    cycle(0, 1, 15); check("ss.set", int'(set3), 1);
                     check("ss.c_hour", int'(hour3), 9);
                     check("ss.c_min", int'(minute3), 59);
                     check("ss.c_sec", int'(second3), 58);
                     check("ss.idle", int'(editing3), 0);

    // Blink on u2 (4-cycle half period), restart on a key, forced low in IDLE.
    cycle(1, 0, 0);
    check("blink.n0", int'(blink2), 1);
    for (int n = 1; n < 8; n++) begin
      cycle(0, 0, 0);
      check($sformatf("blink.n%0d", n), int'(blink2), int'(exp_blink[n]));
    end
    cycle(0, 1, 4'hE); check("blink.key_restart", int'(blink2), 1);
    for (int n = 1; n < 8; n++) begin
      cycle(0, 0, 0);
      check($sformatf("blink.r%0d", n), int'(blink2), int'(exp_blink[n]));
    end
    cycle(0, 1, 15); check("blink.idle_after_enter", int'(blink2), 0);
    cycle(0, 0, 0);  check("blink.idle", int'(blink2), 0);

    // Asynchronous reset in the middle of an edit clears the committed time too.
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    check("rst.pre_hour", int'(hour2), 10);
    #2 rst = 1'b0;
    #1;
    check("rst.async_hour2",   int'(hour2),    0);
    check("rst.async_min2",    int'(minute2),  0);
    check("rst.async_cur2",    int'(cursor2),  0);
    check("rst.async_blink2",  int'(blink2),   0);
    check("rst.async_edit2",   int'(editing2), 0);
    check("rst.async_hour3",   int'(hour3),    0);
    check("rst.async_sec3",    int'(second3),  0);
    check("rst.async_edit3",   int'(editing3), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    cycle(0, 1, 5);
    check("rst.after_edit", int'(editing2), 0);
    check("rst.after_hour", int'(hour2), 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
